// File: rtl/uart_alu_if.sv
// Byte-serial ALU front end: receives A, B and opcode from a UART RX FIFO and returns one result byte (plus a status byte when UART_ALU_IF_STATUS_EN is defined).
// The first wr_uart can come 2 cycles after the opcode pop; tx_full stalls the send states with w_data held, and rx_empty stalls the receive states.
module uart_alu_if #(
   parameter int DBIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_empty,
   input  logic [DBIT-1:0] r_data,
   output logic            rd_uart,
   input  logic            tx_full,
   output logic            wr_uart,
   output logic [DBIT-1:0] w_data,
   output logic            busy
);

   typedef enum logic [2:0] {
      GET_A,
      GET_B,
      GET_OP,
      CALC,
      SEND_RES
`ifdef UART_ALU_IF_STATUS_EN
      ,
      SEND_STAT
`endif
   } state_t;

   state_t          state, state_n;
   logic [DBIT-1:0] a_reg, b_reg, op_reg, result;
   logic            carry, zero, invalid;

   logic [DBIT-1:0] alu_res;
   logic [DBIT:0]   alu_sum;
   logic            alu_carry, alu_inv;

   always_comb begin
      alu_sum   = {1'b0, a_reg} + {1'b0, b_reg};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_inv   = 1'b0;
      // Opcode bits 7:6 are don't-care, so the full byte is matched with wildcards.
      casez (op_reg)
         8'b??10_0000: begin alu_res = alu_sum[DBIT-1:0]; alu_carry = alu_sum[DBIT]; end
         8'b??10_0010: begin alu_res = a_reg - b_reg;     alu_carry = (a_reg < b_reg); end
         8'b??10_0100: alu_res = a_reg & b_reg;
         8'b??10_0101: alu_res = a_reg | b_reg;
         8'b??10_0110: alu_res = a_reg ^ b_reg;
         8'b??10_0111: alu_res = ~(a_reg | b_reg);
         8'b??00_0011: alu_res = $signed(a_reg) >>> b_reg[2:0];
         8'b??00_0010: alu_res = a_reg >> b_reg[2:0];
         default:      alu_inv = 1'b1;
      endcase
   end

   always_comb begin
      state_n = state;
      rd_uart = 1'b0;
      wr_uart = 1'b0;
      w_data  = result;
      case (state)
         GET_A:  if (!rx_empty) begin rd_uart = 1'b1; state_n = GET_B;  end
         GET_B:  if (!rx_empty) begin rd_uart = 1'b1; state_n = GET_OP; end
         GET_OP: if (!rx_empty) begin rd_uart = 1'b1; state_n = CALC;   end
         CALC:   state_n = SEND_RES;
         SEND_RES: begin
            if (!tx_full) begin
               wr_uart = 1'b1;
`ifdef UART_ALU_IF_STATUS_EN
               state_n = SEND_STAT;
`else
               state_n = GET_A;
`endif
            end
         end
`ifdef UART_ALU_IF_STATUS_EN
         SEND_STAT: begin
            w_data = {{(DBIT-3){1'b0}}, invalid, zero, carry};
            if (!tx_full) begin
               wr_uart = 1'b1;
               state_n = GET_A;
            end
         end
`endif
         default: state_n = GET_A;
      endcase
      // Strobes and data are forced quiet for the whole reset pulse, not only after the first edge.
      if (reset) begin
         rd_uart = 1'b0;
         wr_uart = 1'b0;
         w_data  = '0;
      end
   end

   assign busy = !reset && (state != GET_A);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= GET_A;
         a_reg   <= '0;
         b_reg   <= '0;
         op_reg  <= '0;
         result  <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         state <= state_n;
         if (state == GET_A  && rd_uart) a_reg  <= r_data;
         if (state == GET_B  && rd_uart) b_reg  <= r_data;
         if (state == GET_OP && rd_uart) op_reg <= r_data;
         if (state == CALC) begin
            result  <= alu_res;
            carry   <= alu_carry;
            zero    <= (alu_res == '0);
            invalid <= alu_inv;
         end
      end
   end

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: vector table through a byte driver, transmitted bytes checked against an expected-byte queue.
module tb_uart_alu_if;

   logic       clk = 1'b0;
   logic       reset, rx_empty, tx_full;
   logic       rd_uart, wr_uart, busy;
   logic [7:0] r_data, w_data;

   int checks  = 0;
   int errors  = 0;
   int rd_cnt  = 0;
   int n_bytes = 0;
   int cyc     = 0;
   logic [7:0] exp_q[$];

   typedef struct packed {
      logic [7:0] a, b, op, res, stat;
   } vec_t;
   vec_t vecs[15];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   uart_alu_if #(.DBIT(8)) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
      .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart),
      .w_data(w_data), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every transmitted byte must match the oldest expected byte.
   always @(negedge clk) begin
      if (rd_uart === 1'b1) rd_cnt++;
      if (wr_uart === 1'b1) begin
         check("wr_while_full", {31'b0, tx_full}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr: got byte %0h expected no byte", w_data);
         end else begin
            check("tx_byte", {24'b0, w_data}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   // Called and returns at posedge+1; rd_cyc is the cycle the pop was seen.
   task automatic send_byte(input logic [7:0] b, input int gap, output int rd_cyc);
      bit got = 0;
      n_bytes++;
      rd_cyc = -1;
      rx_empty = 1'b1;
      repeat (gap) begin @(posedge clk); #1; end
      rx_empty = 1'b0;
      r_data   = b;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (rd_uart === 1'b1) begin got = 1; rd_cyc = cyc; end
         @(posedge clk); #1;
      end
      rx_empty = 1'b1;
      check("rd_uart_seen", {31'b0, got}, 32'd1);
   endtask

   task automatic push_exp(input logic [7:0] res, input logic [7:0] stat);
      exp_q.push_back(res);
`ifdef UART_ALU_IF_STATUS_EN
      exp_q.push_back(stat);
`endif
   endtask

   task automatic frame(input vec_t v, input int gmax);
      int c;
      push_exp(v.res, v.stat);
      send_byte(v.a,  (gmax == 0) ? 0 : $urandom_range(gmax, 1), c);
      send_byte(v.b,  (gmax == 0) ? 0 : $urandom_range(gmax, 1), c);
      send_byte(v.op, (gmax == 0) ? 0 : $urandom_range(gmax, 1), c);
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && busy === 1'b0) ok = 1;
      end
      check("drain", {31'b0, ok}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;
      bit seen;
      //            A      B      op     res    status
      vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00};
      vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 8'h01};
      vecs[2]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 8'h00};
      vecs[3]  = '{8'h80, 8'h02, 8'h02, 8'h20, 8'h00};
      vecs[4]  = '{8'h12, 8'h34, 8'h3F, 8'h00, 8'h06};
      vecs[5]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h03};
      vecs[6]  = '{8'h0F, 8'hF0, 8'h24, 8'h00, 8'h02};
      vecs[7]  = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00};
      vecs[8]  = '{8'hAA, 8'hFF, 8'h26, 8'h55, 8'h00};
      vecs[9]  = '{8'h0F, 8'hF0, 8'h27, 8'h00, 8'h02};
      vecs[10] = '{8'h05, 8'h05, 8'h22, 8'h00, 8'h02};
      vecs[11] = '{8'h40, 8'h09, 8'h03, 8'h20, 8'h00};
      vecs[12] = '{8'h81, 8'h0F, 8'h02, 8'h01, 8'h00};
      vecs[13] = '{8'h07, 8'h08, 8'hE0, 8'h0F, 8'h00};
      vecs[14] = '{8'h07, 8'h08, 8'h21, 8'h00, 8'h06};

      // Reset with a byte waiting: nothing may be popped or pushed.
      reset = 1'b1; rx_empty = 1'b0; r_data = 8'hAA; tx_full = 1'b0;
      @(negedge clk);
      check("rst_busy",    {31'b0, busy},    32'd0);
      check("rst_rd_uart", {31'b0, rd_uart}, 32'd0);
      check("rst_wr_uart", {31'b0, wr_uart}, 32'd0);
      check("rst_w_data",  {24'b0, w_data},  32'd0);
      @(posedge clk); #1;
      rx_empty = 1'b1; reset = 1'b0;

      foreach (vecs[i]) frame(vecs[i], 0);
      wait_drain();
      foreach (vecs[i]) frame(vecs[i], 5);
      wait_drain();

      // Opcode pop to first write is 2 cycles.
      push_exp(8'h08, 8'h00);
      send_byte(8'h05, 0, c0);
      send_byte(8'h03, 0, c0);
      send_byte(8'h20, 0, c0);
      seen = 0; c1 = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (wr_uart === 1'b1) begin seen = 1; c1 = cyc; end
      end
      check("latency", c1 - c0, 32'd2);
      wait_drain();

      // Transmit FIFO full for 10 cycles in SEND_RES.
      tx_full = 1'b1;
      push_exp(8'hE0, 8'h00);
      send_byte(8'h80, 0, c0);
      send_byte(8'h02, 0, c0);
      send_byte(8'h03, 0, c0);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("full_wr_low", {31'b0, wr_uart}, 32'd0);
         check("full_w_data", {24'b0, w_data},  32'hE0);
      end
      @(posedge clk); #1;
      tx_full = 1'b0;
      wait_drain();

      // Reset after A and B have been taken; partial frame must be dropped.
      send_byte(8'h10, 0, c0);
      send_byte(8'h20, 0, c0);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy",   {31'b0, busy},    32'd0);
      check("midrst_w_data", {24'b0, w_data},  32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_busy2",  {31'b0, busy},    32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("postrst_busy",  {31'b0, busy},    32'd0);
      @(posedge clk); #1;
      frame('{8'h01, 8'h01, 8'h20, 8'h02, 8'h00}, 0);
      wait_drain();

      check("rd_count", rd_cnt, n_bytes);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_alu_if.md
UART_ALU_IF -- requirements
Module: uart_alu_if

Interface
REQ-001 Parameter: DBIT, 8, data byte width (fixed at 8 for this revision).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: rx_empty  input  1  UART receive FIFO empty flag.
REQ-005 Port: r_data  input  8  receive FIFO head word; valid whenever rx_empty=0.
REQ-006 Port: rd_uart  output  1  one-cycle pop strobe to receive FIFO.
REQ-007 Port: tx_full  input  1  UART transmit FIFO full flag.
REQ-008 Port: wr_uart  output  1  push strobe to transmit FIFO.
REQ-009 Port: w_data  output  8  byte pushed to transmit FIFO.
REQ-010 Port: busy  output  1  high whenever state is not GET_A.

Function
REQ-011 Frame is three received bytes in order: operand A, operand B, opcode (r_data[5:0]; bits 7:6 ignored); response is one result byte.
REQ-012 States: GET_A, GET_B, GET_OP, CALC, SEND_RES; GET_A -> GET_B -> GET_OP -> CALC -> SEND_RES -> GET_A.
REQ-013 In GET_A/GET_B/GET_OP with rx_empty=0: capture r_data into the matching register, assert rd_uart that same cycle (combinational from state and rx_empty), and advance; with rx_empty=1: hold, rd_uart=0.
REQ-014 rd_uart is never high for more than one consecutive cycle per byte; it is never asserted outside the GET states.
REQ-015 CALC lasts exactly one cycle and registers result, carry, zero and invalid flags.
REQ-016 Opcodes: 0x20 ADD A+B; 0x22 SUB A-B; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x03 SRA A>>>B[2:0]; 0x02 SRL A>>B[2:0]; results truncated to 8 bits.
REQ-017 carry = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 otherwise; zero = (result==0x00).
REQ-018 Any other opcode: result=0x00, invalid=1, zero=1, carry=0.
REQ-019 SEND_RES: wr_uart=1 when tx_full=0, w_data=result; transition on the cycle wr_uart=1; while tx_full=1, wr_uart=0 and w_data held stable.
REQ-020 wr_uart is high exactly one cycle per transmitted byte.
REQ-021 Latency: last rd_uart (opcode) to first possible wr_uart is 2 cycles.
REQ-022 No new received byte is consumed while in CALC or SEND_RES; back-to-back frames are processed without idle cycles beyond REQ-021.

Reset
REQ-023 While reset=1: state=GET_A, A/B/opcode/result/flag registers=0, w_data=0x00, rd_uart=0, wr_uart=0, busy=0.
REQ-024 Reset asserted mid-frame discards partial operands; the next three received bytes form a fresh frame.

Configuration
REQ-025 Macro UART_ALU_IF_STATUS_EN defined: state SEND_STAT follows SEND_RES, transmitting {5'b0, invalid, zero, carry} under the same rules as REQ-019/020, then returns to GET_A.
REQ-026 Macro UART_ALU_IF_STATUS_EN undefined: SEND_STAT does not exist; exactly one byte is transmitted per frame.

Verification
REQ-027 Bytes 0x05,0x03,0x20 with tx_full=0 -> one wr_uart pulse, w_data=0x08; with macro, second byte 0x00.
REQ-028 Bytes 0x03,0x05,0x22 -> w_data=0xFE; with macro, status 0x01 (borrow).
REQ-029 Bytes 0x80,0x02,0x03 -> w_data=0xE0; bytes 0x80,0x02,0x02 -> w_data=0x20.
REQ-030 Bytes 0x12,0x34,0x3F -> w_data=0x00; with macro, status 0x06.
REQ-031 tx_full held high 10 cycles in SEND_RES -> wr_uart=0 throughout, w_data stable, exactly one pulse after release; rx_empty gaps of 1-5 cycles between bytes -> same results as gap-free stimulus, one rd_uart per byte.
REQ-032 Reset pulse after A and B consumed, then bytes 0x01,0x01,0x20 -> w_data=0x02, busy=0 during and immediately after reset.
